// File: rtl/spi_cmd_ctrl.sv
// SPI (mode 1) command slave: decodes LED-write, PMOD-read and loopback commands,
// with all pin activity oversampled and synchronized into the single clk domain.
module spi_cmd_ctrl #(
  parameter logic [7:0] ID_BYTE = 8'hA5,
  parameter logic [4:0] LED_RST = 5'b00000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_clk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic [7:0] pmod,
  output logic [4:0] led,
  output logic       frame_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_WLED   = 3'd2;
  localparam logic [2:0] S_RPMOD  = 3'd3;
  localparam logic [2:0] S_LOOP   = 3'd4;
  localparam logic [2:0] S_IGNORE = 3'd5;

  logic [2:0] sclkSync_q, csSync_q, mosiSync_q;
  logic [1:0] fill_q;
  logic       armed_q;

  logic [2:0] state_q, state_d;
  logic [2:0] bitCnt_q, bitCnt_d;
  logic [7:0] rxShift_q, rxShift_d;
  logic [7:0] txShift_q, txShift_d;
  logic       miso_q, miso_d;
  logic [4:0] led_q, led_d;
  logic       frameErr_q, frameErr_d;

  logic       sclkRise, sclkFall, csRise, csFall, csActive, mosiS;
  logic [7:0] rxByte;

  // Stage 1/2 synchronize, stage 3 is history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclkSync_q <= 3'b000;
      csSync_q   <= 3'b111;
      mosiSync_q <= 3'b000;
      fill_q     <= 2'b00;
      armed_q    <= 1'b0;
    end else begin
      sclkSync_q <= {sclkSync_q[1:0], spi_clk};
      csSync_q   <= {csSync_q[1:0], spi_cs_n};
      mosiSync_q <= {mosiSync_q[1:0], spi_mosi};
      fill_q     <= {fill_q[0], 1'b1};
      // A frame may only start after cs_n has been seen high since reset.
      if (fill_q[1] && csSync_q[1]) armed_q <= 1'b1;
    end
  end

  assign sclkRise = ~sclkSync_q[2] &  sclkSync_q[1];
  assign sclkFall =  sclkSync_q[2] & ~sclkSync_q[1];
  assign csRise   = ~csSync_q[2]   &  csSync_q[1];
  assign csFall   =  csSync_q[2]   & ~csSync_q[1];
  assign csActive = ~csSync_q[1];
  assign mosiS    =  mosiSync_q[1];
  assign rxByte   = {rxShift_q[6:0], mosiS};

  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    rxShift_d  = rxShift_q;
    txShift_d  = txShift_q;
    miso_d     = miso_q;
    led_d      = led_q;
    frameErr_d = 1'b0;
    if (csRise) begin
      // Deselect wins over any coincident spi_clk edge.
      state_d    = S_IDLE;
      bitCnt_d   = 3'd0;
      rxShift_d  = 8'h00;
      txShift_d  = 8'h00;
      miso_d     = 1'b0;
      frameErr_d = (bitCnt_q != 3'd0);
    end else if (state_q == S_IDLE) begin
      if (csFall && armed_q) begin
        state_d   = S_CMD;
        bitCnt_d  = 3'd0;
        txShift_d = ID_BYTE;
      end
    end else if (csActive) begin
      if (sclkRise) begin
        miso_d    = txShift_q[7];
        txShift_d = {txShift_q[6:0], 1'b0};
      end
      if (sclkFall) begin
        rxShift_d = rxByte;
        bitCnt_d  = bitCnt_q + 3'd1;
        if (bitCnt_q == 3'd7) begin
          case (state_q)
            S_CMD: begin
              case (rxByte)
                8'h01:   begin state_d = S_WLED;   txShift_d = 8'h00; end
                8'h02:   begin state_d = S_RPMOD;  txShift_d = pmod;  end
                8'h03:   begin state_d = S_LOOP;   txShift_d = 8'h03; end
                default: begin state_d = S_IGNORE; txShift_d = 8'h00; end
              endcase
            end
            S_WLED: begin
              led_d     = rxByte[4:0];
              txShift_d = rxByte;
            end
            S_RPMOD: txShift_d = pmod;
            S_LOOP:  txShift_d = rxByte;
            default: txShift_d = 8'h00;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bitCnt_q   <= 3'd0;
      rxShift_q  <= 8'h00;
      txShift_q  <= 8'h00;
      miso_q     <= 1'b0;
      led_q      <= LED_RST;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      rxShift_q  <= rxShift_d;
      txShift_q  <= txShift_d;
      miso_q     <= miso_d;
      led_q      <= led_d;
      frameErr_q <= frameErr_d;
    end
  end

  assign spi_miso  = miso_q;
  assign led       = led_q;
  assign frame_err = frameErr_q;

endmodule
